imem_loader: RTL and testbench
==============================

# imem_loader

Sequential programmer for the processor's 256-word instruction memory. It accepts a byte stream through a valid/ready handshake and packs every four bytes into a little-endian 32-bit word. Each word goes to the instruction-memory write port at consecutive word addresses. While loading, the block holds the processor in reset through `cpu_hold`, so the processor fetches only a completely written program.

## Interface
- `WORDS`, 256, instruction-memory depth in 32-bit words.
- `AW`, 8, word-address width, equal to $clog2(WORDS).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); one clock, reset is asynchronous and active-low.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `nwords`  in  AW+1  number of words to load; latched when `start` is accepted.
- `abort`  in  1  synchronous cancel; effective in any non-IDLE state.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  block can accept a byte this cycle.
- `we`  out  1  instruction-memory write strobe, exactly one cycle per word.
- `waddr`  out  AW  word address for `we`.
- `wdata`  out  32  word for `we`.
- `cpu_hold`  out  1  keeps the processor in reset while 1.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `checksum`  out  32  sum of all written words, modulo 2^32.

## Operation
- States are IDLE, RECV, WRITE and FINISH.
- **IDLE**
  - `start`=1 with 1 ≤ `nwords` ≤ `WORDS`: latch `nwords`, clear the word counter, byte counter and `checksum`, then go to RECV.
  - `start`=1 with `nwords`=0 or `nwords`>`WORDS`: pulse `err` for one cycle and stay in IDLE.
- **RECV**
  - `byte_ready`=1.
  - A byte is accepted on any cycle where `byte_valid` and `byte_ready` are both 1.
  - Byte k (k = 0..3) goes into `wdata[8k+7:8k]`.
  - Acceptance of the 4th byte moves the state to WRITE.
- **WRITE**
  - `we`=1, `waddr`=word counter, `byte_ready`=0.
  - `checksum` += `wdata`, and the word counter increments.
  - If the incremented counter equals `nwords`, go to FINISH. Otherwise go to RECV with the byte counter cleared.
- **FINISH**
  - `done`=1 for one cycle and `cpu_hold` stays 1. Next state is IDLE.
- **Outputs by state**
  - `cpu_hold`=1 and `busy`=1 in RECV, WRITE and FINISH; both are 0 in IDLE.
- **abort**
  - Takes priority over every other transition. The next state is IDLE and `done` is not pulsed.
  - Memory words already written stay written, and `checksum` holds its partial value.
  - A partially assembled word is discarded.
- **Start outside IDLE**
  - `start` while not IDLE is ignored, with no `err`.
- **Last address**
  - The word counter never wraps. `nwords`=`WORDS` writes address `WORDS`-1 last, then goes to FINISH.
- **Reset**
  - While `reset`=0 (including in the middle of a load) the state is IDLE and every output is 0: `byte_ready`, `we`, `waddr`, `wdata`, `cpu_hold`, `busy`, `done`, `err` and `checksum`.

## Timing
- Accepted `start` in cycle t gives `busy`=`cpu_hold`=`byte_ready`=1 in cycle t+1.
- Fourth byte accepted in cycle t gives `we`=1 in cycle t+1. `byte_ready` returns to 1 in t+2 if more words remain.
- Fastest throughput is 5 cycles per word: 4 byte cycles plus 1 write cycle.
- Final WRITE in cycle t gives `done`=1 in t+1 and `cpu_hold`=0 in t+2.
- `err` is asserted in the cycle after the rejected `start`.
- `waddr` and `wdata` are registered and stable for the whole `we` cycle; their values outside `we` are don't-care, except at reset where they are 0.
- `byte_valid` may drop between bytes without losing assembly progress.

## Structure
- Package `imem_loader_pkg` holds:
  - the `loader_state_t` enum {IDLE, RECV, WRITE, FINISH};
  - constants `IMEM_WORDS`=256 and `IMEM_AW`=8, shared with the instruction memory;
  - the byte-lane constant `BYTES_PER_WORD`=4.
- One sub-module, `byte_packer`, contains:
  - a 2-bit byte counter and a 32-bit shift-in register, with inputs `accept` and `clear`;
  - outputs `word` and `word_full`.
- The FSM, word counter and checksum live in `imem_loader`.

## Test plan
- **Basic load:** `nwords`=2, bytes 78 56 34 12 EF BE AD DE with `byte_valid` held at 1. Expect:
  - `we` at address 0 with 0x12345678, then address 1 with 0xDEADBEEF;
  - `done` pulse, then `checksum`=0xF0E21567 and `cpu_hold` low two cycles after the last `we`.
- **Stalled stream:** same data as the basic load, with `byte_valid` toggling every other cycle. Expect identical `we`, `waddr` and `wdata`, and `byte_ready`=0 during each WRITE cycle.
- **Rejects:** `start` with `nwords`=0, then with `nwords`=257. Expect one `err` pulse each, `busy` staying 0 and no `we`.
- **Full depth:** `nwords`=256 with incrementing words 0..255. Expect:
  - last write at `waddr`=255 with `wdata`=255, and no wrap;
  - `checksum`=32640.
- **Abort mid-load:** `abort` after 6 bytes with `nwords`=3. Expect:
  - exactly one `we` before the abort;
  - IDLE next cycle, no `done`, `cpu_hold`=0;
  - a subsequent load behaves normally.
- **Reset mid-load:** drive `reset` low during WRITE. Expect:
  - all outputs 0 immediately, without waiting for a clock edge;
  - after `reset` returns to 1, `busy` stays 0 until a new `start`.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   loader_state_t  - FSM states of the loader
//   IMEM_WORDS/AW   - instruction-memory depth and word-address width
//   BYTES_PER_WORD  - stream bytes packed into one memory word
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } loader_state_t;

  localparam int unsigned IMEM_WORDS     = 256;
  localparam int unsigned IMEM_AW        = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port.
//   byte_valid/byte_data/byte_ready - valid/ready byte stream into the loader
//   we/waddr/wdata                  - instruction-memory write port out of the loader
//   slave  - loader side (consumes bytes, drives the write port)
//   master - environment side (produces bytes, observes the write port)
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int AW = IMEM_AW
);
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, we, waddr, wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four stream bytes into a little-endian 32-bit word.
//   clk, rst_n  - clock, asynchronous active-low reset
//   accept      - a byte is taken this cycle
//   clear       - restart assembly at byte lane 0 (wins over accept)
//   byte_in     - stream byte
//   word        - assembled word (registered)
//   word_full   - the byte taken this cycle completes the word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  // Shifting in from the top leaves byte k in lane k after four bytes.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {byte_in, word_q[31:8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = accept && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: sequential programmer for the instruction memory.
//   clk, reset  - clock, asynchronous active-low reset
//   start       - request a load of nwords words (sampled in IDLE)
//   nwords      - word count, valid range 1..WORDS
//   abort       - synchronous cancel of a load in progress
//   bus         - byte stream in, instruction-memory write port out
//   cpu_hold    - holds the processor in reset during a load
//   busy        - loader not idle
//   done        - one-cycle pulse on load completion
//   err         - one-cycle pulse on a rejected start
//   checksum    - modulo-2^32 sum of words written in the current load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORDS = IMEM_WORDS,
  parameter int AW    = IMEM_AW
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   nwords,
  input  logic          abort,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   checksum
);

  loader_state_t state_q, state_d;
  logic [AW:0]   nwords_q, nwords_d;
  logic [AW:0]   wcnt_q, wcnt_d;
  logic [31:0]   csum_q, csum_d;
  logic          err_q, err_d;

  logic          accept;
  logic          clear;
  logic          word_full;
  logic [31:0]   word;
  logic          nwords_ok;

  assign nwords_ok = (nwords != '0) && (nwords <= (AW+1)'(WORDS));
  assign accept    = bus.byte_valid && bus.byte_ready;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (reset),
    .accept    (accept),
    .clear     (clear),
    .byte_in   (bus.byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    wcnt_d   = wcnt_q;
    csum_d   = csum_q;
    err_d    = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (nwords_ok) begin
            nwords_d = nwords;
            wcnt_d   = '0;
            csum_d   = '0;
            clear    = 1'b1;
            state_d  = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        csum_d  = csum_q + word;
        wcnt_d  = wcnt_q + 1'b1;
        clear   = 1'b1;
        state_d = (wcnt_d == nwords_q) ? FINISH : RECV;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides the transition only; a write in progress still lands
    // and is counted, so the checksum matches the memory contents.
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      nwords_q <= '0;
      wcnt_q   <= '0;
      csum_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      wcnt_q   <= wcnt_d;
      csum_q   <= csum_d;
      err_q    <= err_d;
    end
  end

  assign bus.byte_ready = (state_q == RECV);
  assign bus.we         = (state_q == WRITE);
  assign bus.waddr      = wcnt_q[AW-1:0];
  assign bus.wdata      = word;
  assign busy           = (state_q != IDLE);
  assign cpu_hold       = (state_q != IDLE);
  assign done           = (state_q == FINISH);
  assign err            = err_q;
  assign checksum       = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a write/done scoreboard for imem_loader.
module tb_imem_loader;
  import imem_loader_pkg::*;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  nwords;
  logic        abort;
  logic        cpu_hold, busy, done, err;
  logic [31:0] checksum;

  int unsigned checks   = 0;
  int unsigned passed   = 0;
  int unsigned err_seen = 0;

  wr_t         wq[$];
  logic [31:0] dq[$];

  imem_loader_if #(.AW(8)) bus ();

  imem_loader #(.WORDS(256), .AW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .nwords   (nwords),
    .abort    (abort),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a done pulse.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      chk("ready_low_in_write", {31'd0, bus.byte_ready}, 32'd0);
      if (wq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_we: addr %0d data 0x%08h with nothing expected", bus.waddr, bus.wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("waddr", {24'd0, bus.waddr}, {24'd0, e.addr});
        chk("wdata", bus.wdata, e.data);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: checksum 0x%08h with no load expected", checksum);
      end else begin
        chk("checksum_at_done", checksum, dq.pop_front());
      end
    end
    if (err === 1'b1) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] n);
    start  = 1'b1;
    nwords = n;
    tick();
    start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit acc = 1'b0;
    if (stall) begin
      bus.byte_valid = 1'b0;
      tick();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.byte_ready;
      tick();
    end
    bus.byte_valid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL byte_timeout: byte 0x%02h not accepted within 50 cycles, required acceptance", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},       {31'd0, busy},           32'd0);
    chk({tag, "_cpu_hold"},   {31'd0, cpu_hold},       32'd0);
    chk({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    chk({tag, "_we"},         {31'd0, bus.we},         32'd0);
    chk({tag, "_waddr"},      {24'd0, bus.waddr},      32'd0);
    chk({tag, "_wdata"},      bus.wdata,               32'd0);
    chk({tag, "_done"},       {31'd0, done},           32'd0);
    chk({tag, "_err"},        {31'd0, err},            32'd0);
    chk({tag, "_checksum"},   checksum,                32'd0);
  endtask

  // Two cycles after the last write: done was seen, hold must be released.
  task automatic finish_checks(input string tag, input logic [31:0] csum);
    chk({tag, "_we_last"}, {31'd0, bus.we}, 32'd1);
    tick();
    chk({tag, "_done"},    {31'd0, done},     32'd1);
    chk({tag, "_hold_fin"},{31'd0, cpu_hold}, 32'd1);
    tick();
    chk({tag, "_hold_off"},{31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy_off"},{31'd0, busy},     32'd0);
    chk({tag, "_checksum"}, checksum, csum);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    start          = 1'b0;
    nwords         = '0;
    abort          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Basic load
    wq.push_back('{8'd0, 32'h1234_5678});
    wq.push_back('{8'd1, 32'hDEAD_BEEF});
    dq.push_back(32'hF0E2_1567);
    do_start(9'd2);
    chk("start_busy",  {31'd0, busy},           32'd1);
    chk("start_hold",  {31'd0, cpu_hold},       32'd1);
    chk("start_ready", {31'd0, bus.byte_ready}, 32'd1);
    send_word(32'h1234_5678, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    finish_checks("basic", 32'hF0E2_1567);

    // Stalled stream
    wq.push_back('{8'd0, 32'h1234_5678});
    wq.push_back('{8'd1, 32'hDEAD_BEEF});
    dq.push_back(32'hF0E2_1567);
    do_start(9'd2);
    send_word(32'h1234_5678, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1);
    finish_checks("stall", 32'hF0E2_1567);

    // Rejected starts
    do_start(9'd0);
    chk("rej0_err",  {31'd0, err},  32'd1);
    chk("rej0_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rej0_err_pulse", {31'd0, err}, 32'd0);
    do_start(9'd257);
    chk("rej257_err",  {31'd0, err},  32'd1);
    chk("rej257_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rej257_busy2", {31'd0, busy}, 32'd0);

    // Full depth
    for (int i = 0; i < 256; i++) wq.push_back('{8'(i), 32'(i)});
    dq.push_back(32'd32640);
    do_start(9'd256);
    for (int i = 0; i < 256; i++) send_word(32'(i), 1'b0);
    finish_checks("full", 32'd32640);

    // Abort mid-load after six bytes
    wq.push_back('{8'd0, 32'hA1B2_C3D4});
    do_start(9'd3);
    send_word(32'hA1B2_C3D4, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy",     {31'd0, busy},     32'd0);
    chk("abort_hold",     {31'd0, cpu_hold}, 32'd0);
    chk("abort_done",     {31'd0, done},     32'd0);
    chk("abort_checksum", checksum,          32'hA1B2_C3D4);
    tick();
    chk("abort_done2",    {31'd0, done},     32'd0);

    wq.push_back('{8'd0, 32'hCAFE_F00D});
    dq.push_back(32'hCAFE_F00D);
    do_start(9'd1);
    send_word(32'hCAFE_F00D, 1'b0);
    finish_checks("after_abort", 32'hCAFE_F00D);

    // Reset during the second WRITE of a three-word load
    wq.push_back('{8'd0, 32'h0BAD_C0DE});
    wq.push_back('{8'd1, 32'h0000_0001});
    do_start(9'd3);
    send_word(32'h0BAD_C0DE, 1'b0);
    send_word(32'h0000_0001, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_busy", {31'd0, busy}, 32'd0);
    end

    wq.push_back('{8'd0, 32'h55AA_55AA});
    dq.push_back(32'h55AA_55AA);
    do_start(9'd1);
    send_word(32'h55AA_55AA, 1'b0);
    finish_checks("after_reset", 32'h55AA_55AA);

    tick();
    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("dones_drained",  32'(dq.size()), 32'd0);
    chk("err_count",      32'(err_seen),  32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
